// File: rtl/present_pkg.sv
// ---------------------------------------------------------------------------
// present_pkg
// Shared definitions for the PRESENT-80 control stage: register map
// addresses, FSM state encoding, round count and the default RUN timeout.
// No ports (package).
// ---------------------------------------------------------------------------
package present_pkg;

    // Register map for the 32-bit write port.
    localparam logic [2:0] ADDR_PT_LO   = 3'd0;
    localparam logic [2:0] ADDR_PT_HI   = 3'd1;
    localparam logic [2:0] ADDR_KEY_LO  = 3'd2;
    localparam logic [2:0] ADDR_KEY_MID = 3'd3;
    localparam logic [2:0] ADDR_KEY_HI  = 3'd4;

    // The core needs one cycle per round after the load pulse.
    localparam int PRESENT_ROUNDS = 32;

    // Default RUN budget leaves some slack over the nominal round count.
    localparam int DEFAULT_TIMEOUT_CYC = PRESENT_ROUNDS + 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HOLD
    } ctrl_state_e;

endpackage

// File: rtl/present_ctrl_regs.sv
// ---------------------------------------------------------------------------
// present_ctrl_regs
// Write decode and storage for the 64-bit plaintext and 80-bit key.
// Writes only land while the controller is idle.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   wr_en_i            write strobe
//   idle_i             controller is in IDLE (write gate)
//   wr_addr_i          register select
//   wr_data_i          write data
//   pt_o               plaintext register
//   key_o              key register
// ---------------------------------------------------------------------------
module present_ctrl_regs
    import present_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic        idle_i,
    input  logic [2:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic [63:0] pt_o,
    output logic [79:0] key_o
);

    logic [63:0] pt_q;
    logic [79:0] key_q;

    // Operand registers; they persist across encryptions so a repeat run
    // needs no rewrite. Addresses 5-7 fall through and change nothing.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pt_q  <= '0;
            key_q <= '0;
        end else if (wr_en_i && idle_i) begin
            case (wr_addr_i)
                ADDR_PT_LO:   pt_q[31:0]   <= wr_data_i;
                ADDR_PT_HI:   pt_q[63:32]  <= wr_data_i;
                ADDR_KEY_LO:  key_q[31:0]  <= wr_data_i;
                ADDR_KEY_MID: key_q[63:32] <= wr_data_i;
                ADDR_KEY_HI:  key_q[79:64] <= wr_data_i[15:0];
                default: ;
            endcase
        end
    end

    assign pt_o  = pt_q;
    assign key_o = key_q;

endmodule

// File: rtl/present_ctrl.sv
// ---------------------------------------------------------------------------
// present_ctrl
// Control and buffering stage in front of a PRESENT-80 core. Collects the
// operands, issues a one-cycle load pulse, keeps the core enabled through
// the rounds, captures the ciphertext on core_done and offers it on a
// valid/ready port.
// Optional feature: define PRESENT_CTRL_TIMEOUT_EN to abort RUN after
// TIMEOUT_CYC cycles without core_done and raise the sticky err flag.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   wr_en_i/wr_addr_i/wr_data_i   operand register writes
//   start_i                       request one encryption
//   busy_o                        not idle
//   out_valid_o/out_ready_i       ciphertext handshake
//   out_data_o                    captured ciphertext
//   err_o                         sticky timeout flag
//   core_ce_o/core_load_o         core enable and load pulse
//   core_idat_o/core_key_o        operands to core
//   core_odat_i/core_done_i       core result and completion pulse
// ---------------------------------------------------------------------------
module present_ctrl
    import present_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
)
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_data_o,
    output logic        err_o,
    output logic        core_ce_o,
    output logic        core_load_o,
    output logic [63:0] core_idat_o,
    output logic [79:0] core_key_o,
    input  logic [63:0] core_odat_i,
    input  logic        core_done_i
);

    ctrl_state_e state_q, state_d;
    logic [63:0] outData_q, outData_d;
    logic        timeoutHit;

    present_ctrl_regs uRegs (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_en_i),
        .idle_i    (state_q == ST_IDLE),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .pt_o      (core_idat_o),
        .key_o     (core_key_o)
    );

`ifdef PRESENT_CTRL_TIMEOUT_EN
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_CYC - 1);

    logic [5:0] runCnt_q;
    logic       err_q;

    // core_done wins over an abort landing in the same cycle.
    assign timeoutHit = (state_q == ST_RUN) && !core_done_i && (runCnt_q == TIMEOUT_LAST);

    // Counts RUN cycles; zeroed while in LOAD so it starts clean on RUN entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            runCnt_q <= '0;
        end else if (state_q == ST_LOAD) begin
            runCnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            runCnt_q <= runCnt_q + 6'd1;
        end
    end

    // Sticky until the next accepted start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && start_i) begin
            err_q <= 1'b0;
        end else if (timeoutHit) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeoutHit = 1'b0;
    assign err_o      = 1'b0;
`endif

    // State and captured ciphertext; reset discards any in-flight result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            outData_q <= '0;
        end else begin
            state_q   <= state_d;
            outData_q <= outData_d;
        end
    end

    // Next state. start and core_done only matter in their own states.
    always_comb begin
        state_d   = state_q;
        outData_d = outData_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (core_done_i) begin
                    state_d   = ST_HOLD;
                    outData_d = core_odat_i;
                end else if (timeoutHit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are pure decodes of the current state.
    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        out_valid_o = (state_q == ST_HOLD);
        core_ce_o   = (state_q == ST_LOAD) || (state_q == ST_RUN);
        core_load_o = (state_q == ST_LOAD);
    end

    assign out_data_o = outData_q;

endmodule

// File: tb/tb_present_ctrl.sv
// ---------------------------------------------------------------------------
// tb_present_ctrl
// Self-checking bench for present_ctrl: a behavioural PRESENT-80 core model
// answers the load pulse, a table of known vectors plus random operands are
// encrypted, and hand-written sequences cover interference, back-pressure,
// mid-run reset and (when PRESENT_CTRL_TIMEOUT_EN is defined) the timeout.
// ---------------------------------------------------------------------------
module tb_present_ctrl;
    import present_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        err;
    logic        core_ce;
    logic        core_load;
    logic [63:0] core_idat;
    logic [79:0] core_key;
    logic [63:0] core_odat;
    logic        core_done;

    int tests = 0;
    int fails = 0;

    present_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .start_i     (start),
        .busy_o      (busy),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .err_o       (err),
        .core_ce_o   (core_ce),
        .core_load_o (core_load),
        .core_idat_o (core_idat),
        .core_key_o  (core_key),
        .core_odat_i (core_odat),
        .core_done_i (core_done)
    );

    always #5 clk = ~clk;

    // PRESENT-80 reference: straight from the cipher definition.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tab;
        tab = 64'h21748FE3DA09B65C;
        return tab[4*x +: 4];
    endfunction

    function automatic logic [63:0] presentEnc(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s, p;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
            p = '0;
            for (int b = 0; b < 64; b++) p[(b == 63) ? 63 : (b * 16) % 63] = s[b];
            s = p;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ r[4:0];
        end
        return s ^ k[79:16];
    endfunction

    // Core model: sees the load pulse, then raises done for one cycle so
    // that it is sampled 32 edges after the edge that leaves LOAD.
    int          coreCnt = 0;
    int          loadCount = 0;
    logic        coreMute = 1'b0;
    logic        coreDoneModel = 1'b0;
    logic        forceDone = 1'b0;
    logic [63:0] coreResult = '0;

    assign core_done = coreDoneModel | forceDone;
    assign core_odat = coreResult;

    always @(negedge clk) begin
        if (core_load) begin
            loadCount++;
            coreResult = presentEnc(core_idat, core_key);
            coreCnt = 32;
            coreDoneModel = 1'b0;
        end else if (coreCnt > 0) begin
            coreDoneModel = (coreCnt == 1) && !coreMute;
            coreCnt--;
        end else begin
            coreDoneModel = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step(1);
        wr_en   = 1'b0;
    endtask

    // Waits for out_valid counting edges from the start-sampling edge (=1).
    task automatic waitValid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step(1);
            lat++;
        end
    endtask

    // One full encryption. The high key write shares its cycle with start.
    task automatic encrypt(input logic [63:0] pt, input logic [79:0] key, input logic [63:0] expCt,
                           input string tag, input bit writePt, input bit writeKey);
        int l0;
        int lat;
        l0 = loadCount;
        if (writePt) begin
            applyStimulus(ADDR_PT_LO, pt[31:0]);
            applyStimulus(ADDR_PT_HI, pt[63:32]);
        end
        if (writeKey) begin
            applyStimulus(ADDR_KEY_LO, key[31:0]);
            applyStimulus(ADDR_KEY_MID, key[63:32]);
            wr_en   = 1'b1;
            wr_addr = ADDR_KEY_HI;
            wr_data = {16'($urandom), key[79:64]};
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        wr_en = 1'b0;
        waitValid(lat);
        checkOutput({tag, "_latency"}, 80'(lat), 80'd34);
        checkOutput({tag, "_data"}, 80'(out_data), 80'(expCt));
        checkOutput({tag, "_idat"}, 80'(core_idat), 80'(pt));
        checkOutput({tag, "_key"}, core_key, key);
        checkOutput({tag, "_loads"}, 80'(loadCount - l0), 80'd1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checkOutput({tag, "_validFall"}, 80'(out_valid), 80'd0);
        checkOutput({tag, "_idleAfter"}, 80'(busy), 80'd0);
        checkOutput({tag, "_dataHeld"}, 80'(out_data), 80'(expCt));
    endtask

    typedef struct {
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] ct;
        bit          writePt;
        bit          writeKey;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [63:0] rpt, prevData;
        logic [79:0] rkey;
        int          l0, lat, okCycles;

        tbl[0] = '{64'h0, 80'h0, 64'h5579C1387B228445, 1'b1, 1'b1};
        tbl[1] = '{64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b1, 1'b1};
        tbl[2] = '{{64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b1, 1'b0};
        tbl[3] = '{{64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b0, 1'b1};
        tbl[4] = '{{64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b0, 1'b0};

        // Reset state.
        step(2);
        checkOutput("rst_busy", 80'(busy), 80'd0);
        checkOutput("rst_valid", 80'(out_valid), 80'd0);
        checkOutput("rst_data", 80'(out_data), 80'd0);
        checkOutput("rst_err", 80'(err), 80'd0);
        checkOutput("rst_ce", 80'(core_ce), 80'd0);
        checkOutput("rst_load", 80'(core_load), 80'd0);
        checkOutput("rst_idat", 80'(core_idat), 80'd0);
        checkOutput("rst_key", core_key, 80'd0);
        rst_n = 1'b1;
        step(1);

        // Known vectors, including re-encryption without rewrite and a
        // back-to-back start in the first idle cycle.
        for (int i = 0; i < 5; i++) begin
            encrypt(tbl[i].pt, tbl[i].key, tbl[i].ct, $sformatf("vec%0d", i), tbl[i].writePt, tbl[i].writeKey);
        end

        // Random operands against the reference model.
        for (int i = 0; i < 6; i++) begin
            rpt  = {$urandom, $urandom};
            rkey = {16'($urandom), $urandom, $urandom};
            encrypt(rpt, rkey, presentEnc(rpt, rkey), $sformatf("rand%0d", i), 1'b1, 1'b1);
        end

        // Unused addresses must not disturb the operands.
        applyStimulus(3'd5, 32'hDEADBEEF);
        applyStimulus(3'd6, 32'hDEADBEEF);
        applyStimulus(3'd7, 32'hDEADBEEF);
        checkOutput("unusedAddr_idat", 80'(core_idat), 80'(rpt));
        checkOutput("unusedAddr_key", core_key, rkey);

        // Writes and starts while busy are ignored; back-pressure holds.
        rpt  = 64'h0123456789ABCDEF;
        rkey = 80'h00112233445566778899;
        applyStimulus(ADDR_PT_LO, rpt[31:0]);
        applyStimulus(ADDR_PT_HI, rpt[63:32]);
        applyStimulus(ADDR_KEY_LO, rkey[31:0]);
        applyStimulus(ADDR_KEY_MID, rkey[63:32]);
        applyStimulus(ADDR_KEY_HI, {16'h0, rkey[79:64]});
        l0 = loadCount;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        for (int a = 0; a < 5; a++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(a);
            wr_data = $urandom;
            start   = 1'b1;
            step(1);
        end
        wr_en = 1'b0;
        start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step(1);
            lat++;
        end
        checkOutput("busyIgn_valid", 80'(out_valid), 80'd1);
        checkOutput("busyIgn_data", 80'(out_data), 80'(presentEnc(rpt, rkey)));
        okCycles = 0;
        for (int c = 0; c < 100; c++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(c % 5);
            wr_data = $urandom;
            start   = 1'b1;
            step(1);
            if (out_valid && !core_ce && !core_load && busy && out_data === presentEnc(rpt, rkey)) okCycles++;
        end
        wr_en = 1'b0;
        start = 1'b0;
        checkOutput("hold_stableCycles", 80'(okCycles), 80'd100);
        checkOutput("hold_loads", 80'(loadCount - l0), 80'd1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checkOutput("hold_validFall", 80'(out_valid), 80'd0);
        checkOutput("busyIgn_idat", 80'(core_idat), 80'(rpt));
        checkOutput("busyIgn_key", core_key, rkey);

        // Stray core_done in IDLE has no effect.
        prevData = out_data;
        forceDone = 1'b1;
        step(1);
        forceDone = 1'b0;
        checkOutput("strayDone_busy", 80'(busy), 80'd0);
        checkOutput("strayDone_valid", 80'(out_valid), 80'd0);
        checkOutput("strayDone_data", 80'(out_data), 80'(prevData));

        // Reset in RUN cycle 10 discards everything; the late done is ignored.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        checkOutput("midRst_preBusy", 80'(busy), 80'd1);
        rst_n = 1'b0;
        step(1);
        checkOutput("midRst_busy", 80'(busy), 80'd0);
        checkOutput("midRst_valid", 80'(out_valid), 80'd0);
        checkOutput("midRst_ce", 80'(core_ce), 80'd0);
        checkOutput("midRst_data", 80'(out_data), 80'd0);
        checkOutput("midRst_idat", 80'(core_idat), 80'd0);
        checkOutput("midRst_key", core_key, 80'd0);
        rst_n = 1'b1;
        step(40);
        checkOutput("lateDone_valid", 80'(out_valid), 80'd0);
        checkOutput("lateDone_busy", 80'(busy), 80'd0);
        checkOutput("lateDone_data", 80'(out_data), 80'd0);

`ifdef PRESENT_CTRL_TIMEOUT_EN
        // Silent core: abort after 40 RUN cycles, then a new start clears err.
        encrypt(64'h0, 80'h0, 64'h5579C1387B228445, "preTo", 1'b0, 1'b0);
        prevData = out_data;
        coreMute = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(40);
        checkOutput("to_stillBusy", 80'(busy), 80'd1);
        checkOutput("to_errLow", 80'(err), 80'd0);
        step(1);
        checkOutput("to_busy", 80'(busy), 80'd0);
        checkOutput("to_err", 80'(err), 80'd1);
        checkOutput("to_valid", 80'(out_valid), 80'd0);
        checkOutput("to_data", 80'(out_data), 80'(prevData));
        step(3);
        checkOutput("to_errSticky", 80'(err), 80'd1);
        coreMute = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        checkOutput("to_errCleared", 80'(err), 80'd0);
        waitValid(lat);
        checkOutput("to_recoverLat", 80'(lat), 80'd34);
        checkOutput("to_recoverData", 80'(out_data), 80'h5579C1387B228445);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
`else
        checkOutput("noTo_err", 80'(err), 80'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
